// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator / monitor family.
package seq_pkg;
  localparam int DEF_W    = 4;
  localparam int DEF_STEP = 1;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    LOCKED = 2'b01
  } seq_state_e;
endpackage

// File: rtl/seq_mon_satcnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module seq_mon_satcnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/seq_mon.sv
// Checks that each valid sample equals previous+STEP (mod 2^W); lock/unlock FSM,
// error pulse and saturating error count. SEQ_MON_CAPTURE_EN adds err_exp/err_act capture.
module seq_mon
  import seq_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int STEP     = DEF_STEP,
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
`ifdef SEQ_MON_CAPTURE_EN
  ,
  output logic [W-1:0]     err_exp,
  output logic [W-1:0]     err_act
`endif
);
  localparam int RUN_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(UNLOCK_N + 1);
  localparam logic [W-1:0]      STEP_W   = W'(STEP);
  localparam logic [RUN_W-1:0]  LOCK_V   = RUN_W'(LOCK_N);
  localparam logic [MISS_W-1:0] UNLOCK_V = MISS_W'(UNLOCK_N);

  seq_state_e        state_q, state_d;
  logic              have_prev_q, have_prev_d;
  logic [W-1:0]      prev_q, prev_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              cnt_inc;
  logic [W-1:0]      expect_w;
  logic              good;

  // Expectation wraps naturally in W bits.
  assign expect_w = prev_q + STEP_W;
  assign good     = (in_data == expect_w);

  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    cnt_inc     = 1'b0;
    if (clr) begin
      have_prev_d = 1'b0;
      state_d     = HUNT;
      run_d       = '0;
      miss_d      = '0;
    end else if (in_valid) begin
      // Always re-seed on the received value, good or bad.
      prev_d = in_data;
      if (!have_prev_q) begin
        have_prev_d = 1'b1;
      end else begin
        case (state_q)
          HUNT: begin
            if (good) begin
              if (run_q + 1'b1 == LOCK_V) begin
                state_d = LOCKED;
                run_d   = '0;
                miss_d  = '0;
              end else begin
                run_d = run_q + 1'b1;
              end
            end else begin
              run_d = '0;
            end
          end
          LOCKED: begin
            if (good) begin
              miss_d = '0;
            end else begin
              err_d   = 1'b1;
              cnt_inc = 1'b1;
              if (miss_q + 1'b1 == UNLOCK_V) begin
                state_d = HUNT;
                run_d   = '0;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      have_prev_q <= 1'b0;
      prev_q      <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  seq_mon_satcnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (cnt_inc),
    .cnt (err_cnt)
  );

  assign locked = locked_q;
  assign err    = err_q;

`ifdef SEQ_MON_CAPTURE_EN
  logic [W-1:0] err_exp_q, err_exp_d, err_act_q, err_act_d;

  always_comb begin
    err_exp_d = err_exp_q;
    err_act_d = err_act_q;
    if (clr) begin
      err_exp_d = '0;
      err_act_d = '0;
    end else if (cnt_inc) begin
      err_exp_d = expect_w;
      err_act_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_exp_q <= '0;
      err_act_q <= '0;
    end else begin
      err_exp_q <= err_exp_d;
      err_act_q <= err_act_d;
    end
  end

  assign err_exp = err_exp_q;
  assign err_act = err_act_q;
`endif
endmodule

// File: tb/tb_seq_mon.sv
// Directed bench for seq_mon: lock, errors/unlock, wrap, saturation, gaps, clr, reset.
module tb_seq_mon;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       clr = 1'b0;
  logic       a_locked, a_err;
  logic [7:0] a_cnt;
  logic       b_locked, b_err;
  logic [1:0] b_cnt;
`ifdef SEQ_MON_CAPTURE_EN
  logic [3:0] a_exp, a_act, b_exp, b_act;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mon #(.W(4), .STEP(1), .LOCK_N(3), .UNLOCK_N(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(a_locked), .err(a_err), .err_cnt(a_cnt)
`ifdef SEQ_MON_CAPTURE_EN
    , .err_exp(a_exp), .err_act(a_act)
`endif
  );

  seq_mon #(.W(4), .STEP(1), .LOCK_N(3), .UNLOCK_N(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(b_locked), .err(b_err), .err_cnt(b_cnt)
`ifdef SEQ_MON_CAPTURE_EN
    , .err_exp(b_exp), .err_act(b_act)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, leave outputs settled 1 time unit after the rise.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic smp(input logic [3:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_locked", {31'b0, a_locked}, 0);
    chk("rst_err", {31'b0, a_err}, 0);
    chk("rst_cnt", {24'b0, a_cnt}, 0);
    rst = 1'b1;

    // lock acquisition
    smp(0); smp(1); smp(2);
    chk("lock_pre", {31'b0, a_locked}, 0);
    chk("lock_pre_err", {31'b0, a_err}, 0);
    smp(3);
    chk("lock_on", {31'b0, a_locked}, 1);
    chk("lock_cnt", {24'b0, a_cnt}, 0);
    // errors and unlock
    smp(5);
    chk("e5_err", {31'b0, a_err}, 1);
    chk("e5_cnt", {24'b0, a_cnt}, 1);
    chk("e5_locked", {31'b0, a_locked}, 1);
    smp(6);
    chk("g6_err", {31'b0, a_err}, 0);
    chk("g6_locked", {31'b0, a_locked}, 1);
    smp(8);
    chk("e8_err", {31'b0, a_err}, 1);
    chk("e8_cnt", {24'b0, a_cnt}, 2);
    chk("e8_locked", {31'b0, a_locked}, 1);
    smp(10);
    chk("e10_err", {31'b0, a_err}, 1);
    chk("e10_cnt", {24'b0, a_cnt}, 3);
    chk("e10_unlock", {31'b0, a_locked}, 0);
    step(1'b0, 4'd11, 1'b0);
    chk("idle_err", {31'b0, a_err}, 0);
    chk("idle_cnt", {24'b0, a_cnt}, 3);

    // wrap-around
    do_reset();
    smp(13); smp(14); smp(15);
    chk("wrap_pre", {31'b0, a_locked}, 0);
    smp(0);
    chk("wrap_lock", {31'b0, a_locked}, 1);
    chk("wrap_err", {31'b0, a_err}, 0);
    smp(1);
    chk("wrap_cnt", {24'b0, a_cnt}, 0);

    // saturation on the narrow-counter instance
    do_reset();
    smp(0); smp(1); smp(2); smp(3);
    chk("sat_lock", {31'b0, b_locked}, 1);
    smp(7);  chk("sat_c1", {30'b0, b_cnt}, 1);
    smp(9);  chk("sat_c2", {30'b0, b_cnt}, 2);
    smp(11); chk("sat_c3", {30'b0, b_cnt}, 3);
    chk("sat_still_locked", {31'b0, b_locked}, 1);
    smp(12); smp(13); smp(14); smp(15); smp(0);
    chk("sat_good_err", {31'b0, b_err}, 0);
    smp(5);
    chk("sat_err", {31'b0, b_err}, 1);
    chk("sat_hold", {30'b0, b_cnt}, 3);

    // gaps between samples
    do_reset();
    smp(0); step(1'b0, 4'd9, 1'b0);
    smp(1); step(1'b0, 4'd9, 1'b0);
    smp(2); step(1'b0, 4'd9, 1'b0);
    chk("gap_pre", {31'b0, a_locked}, 0);
    smp(3);
    chk("gap_lock", {31'b0, a_locked}, 1);
    smp(7);
    chk("gap_e_cnt", {24'b0, a_cnt}, 1);

    // clr with simultaneous valid
    step(1'b1, 4'd9, 1'b1);
    chk("clr_locked", {31'b0, a_locked}, 0);
    chk("clr_cnt", {24'b0, a_cnt}, 0);
    chk("clr_err", {31'b0, a_err}, 0);
    smp(10); smp(11); smp(12);
    chk("clr_seed_only", {31'b0, a_locked}, 0);
    smp(13);
    chk("clr_relock", {31'b0, a_locked}, 1);

    // async reset mid-cycle while locked
    smp(15);
    chk("pre_rst_cnt", {24'b0, a_cnt}, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_locked", {31'b0, a_locked}, 0);
    chk("arst_cnt", {24'b0, a_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;
    smp(5); smp(6); smp(7);
    chk("arst_seed", {31'b0, a_locked}, 0);
    smp(8);
    chk("arst_relock", {31'b0, a_locked}, 1);

`ifdef SEQ_MON_CAPTURE_EN
    do_reset();
    chk("cap_rst_exp", {28'b0, a_exp}, 0);
    chk("cap_rst_act", {28'b0, a_act}, 0);
    smp(0); smp(1); smp(2); smp(3);
    smp(7);
    chk("cap_exp", {28'b0, a_exp}, 4);
    chk("cap_act", {28'b0, a_act}, 7);
    smp(8); smp(9);
    chk("cap_hold_exp", {28'b0, a_exp}, 4);
    chk("cap_hold_act", {28'b0, a_act}, 7);
    step(1'b0, 4'd0, 1'b1);
    chk("cap_clr_exp", {28'b0, a_exp}, 0);
    chk("cap_clr_act", {28'b0, a_act}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
